lr_intctl: RTL and testbench

//  Interrupt controller feeding the lr35902 core's intreq/intaddress/intack handshake.

---
 rtl/lr_intctl_pkg.sv | 42 ++++
 rtl/lr_intctl_prio_enc.sv | 33 +++
 rtl/lr_intctl.sv | 145 ++++++++++++++
 tb/tb_lr_intctl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lr_intctl_pkg.sv
// ============================================================================
// Module  : lr_intctl_pkg
// Brief   : Shared constants, source indices, FSM state type and vector
//           helper for the lr35902 interrupt controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package lr_intctl_pkg;

  // Register map and vector table defaults
  localparam int unsigned NUM_SRC_DEF    = 5;
  localparam logic [15:0] VEC_BASE_DEF   = 16'h0040;
  localparam logic [15:0] VEC_STRIDE_DEF = 16'h0008;
  localparam logic [15:0] IF_ADDR_DEF    = 16'hff0f;
  localparam logic [15:0] IE_ADDR_DEF    = 16'hffff;

  // Request source indices; lower index means higher priority
  localparam int unsigned INT_VBLANK = 0;
  localparam int unsigned INT_STAT   = 1;
  localparam int unsigned INT_TIMER  = 2;
  localparam int unsigned INT_SERIAL = 3;
  localparam int unsigned INT_JOYPAD = 4;

  // Request FSM states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } int_state_e;

  // Vector address for a source index: base + idx*stride, 16-bit unsigned
  function automatic logic [15:0] int_vector(
    input logic [15:0] base,
    input logic [15:0] stride,
    input logic [7:0]  idx
  );
    return base + (stride * {8'd0, idx});
  endfunction

endpackage

`default_nettype wire

// File: rtl/lr_intctl_prio_enc.sv
// ============================================================================
// Module  : lr_intctl_prio_enc
// Brief   : Lowest-set-bit priority encoder. Returns the index of the lowest
//           asserted request bit and a flag that any bit is asserted.
//           Purely combinational.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lr_intctl_prio_enc #(
  parameter int unsigned N     = 5,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             vld_o
);

  // Scan from the top down so the lowest asserted bit is the last one written
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = IDX_W'(i);
        vld_o = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/lr_intctl.sv
// ============================================================================
// Module  : lr_intctl
// Brief   : Interrupt controller for the lr35902 core. Edge-detects the
//           peripheral request lines into IF, masks with IE, and presents the
//           highest-priority vector on the intreq/intaddress/intack handshake.
//           IF and IE are readable/writable on the core bus.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lr_intctl
  import lr_intctl_pkg::*;
#(
  parameter int unsigned NUM_SRC    = NUM_SRC_DEF,
  parameter logic [15:0] VEC_BASE   = VEC_BASE_DEF,
  parameter logic [15:0] VEC_STRIDE = VEC_STRIDE_DEF,
  parameter logic [15:0] IF_ADDR    = IF_ADDR_DEF,
  parameter logic [15:0] IE_ADDR    = IE_ADDR_DEF
) (
  input  logic               clock4,
  input  logic               resetn,
  input  logic [15:0]        address,
  input  logic [7:0]         wdata,
  input  logic               load,
  input  logic               store,
  output logic [7:0]         rdata,
  output logic               rsel,
  input  logic [NUM_SRC-1:0] src,
  output logic               intreq,
  output logic [15:0]        intaddress,
  input  logic               intack
);

  // Index width for up to 8 sources (IF shares one byte with the unused 1s)
  localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] if_q;
  logic [NUM_SRC-1:0] if_d;
  logic [7:0]         ie_q;
  logic [7:0]         ie_d;
  int_state_e         state_q;
  logic [IDX_W-1:0]   idx_q;

  logic [NUM_SRC-1:0] rise_w;
  logic [NUM_SRC-1:0] pend_w;
  logic [IDX_W-1:0]   win_idx_w;
  logic               win_vld_w;
  logic               if_wr_w;
  logic               ie_wr_w;
  logic               ack_take_w;
  logic [7:0]         if_rd_w;

  assign if_wr_w    = store && (address == IF_ADDR);
  assign ie_wr_w    = store && (address == IE_ADDR);
  assign rise_w     = src & ~src_q;
  assign pend_w     = if_q & ie_q[NUM_SRC-1:0];
  // An ack only counts while a request is actually outstanding
  assign ack_take_w = intack && (state_q == ST_REQ);

  lr_intctl_prio_enc #(
    .N     (NUM_SRC),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .req_i (pend_w),
    .idx_o (win_idx_w),
    .vld_o (win_vld_w)
  );

  // IF next state: bus write, else ack-clear, then new edges always win
  always_comb begin
    if_d = if_q;
    if (if_wr_w) begin
      if_d = wdata[NUM_SRC-1:0];
    end else if (ack_take_w) begin
      if_d[idx_q] = 1'b0;
    end
    if_d = if_d | rise_w;
  end

  assign ie_d = ie_wr_w ? wdata : ie_q;

  // Register file and request-line history
  always_ff @(posedge clock4 or negedge resetn) begin
    if (!resetn) begin
      src_q <= '0;
      if_q  <= '0;
      ie_q  <= '0;
    end else begin
      src_q <= src;
      if_q  <= if_d;
      ie_q  <= ie_d;
    end
  end

  // Request FSM: latch the winner, hold it until acked or cancelled
  always_ff @(posedge clock4 or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      intreq     <= 1'b0;
      intaddress <= 16'h0000;
      idx_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_vld_w) begin
            state_q    <= ST_REQ;
            idx_q      <= win_idx_w;
            intaddress <= int_vector(VEC_BASE, VEC_STRIDE, 8'(win_idx_w));
            intreq     <= 1'b1;
          end
        end
        ST_REQ: begin
          // Vector stays frozen; leave on ack or when its own bit is cancelled
          if (intack || !pend_w[idx_q]) begin
            state_q <= ST_IDLE;
            intreq  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          intreq  <= 1'b0;
        end
      endcase
    end
  end

  // Read mux: IF reads back with 1s in the unimplemented upper bits
  always_comb begin
    if_rd_w              = 8'hFF;
    if_rd_w[NUM_SRC-1:0] = if_q;
    rsel                 = 1'b0;
    rdata                = 8'h00;
    if (load && (address == IF_ADDR)) begin
      rsel  = 1'b1;
      rdata = if_rd_w;
    end else if (load && (address == IE_ADDR)) begin
      rsel  = 1'b1;
      rdata = ie_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lr_intctl.sv
// ============================================================================
// Module  : tb_lr_intctl
// Brief   : Scoreboard bench for lr_intctl. A reference model predicts each
//           intreq transition (edge number, level, vector) and each register
//           read; a monitor compares them as the DUT presents them.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lr_intctl;
  import lr_intctl_pkg::*;

  localparam logic [15:0] A_IF = 16'hFF0F;
  localparam logic [15:0] A_IE = 16'hFFFF;
  localparam logic [4:0]  S_VB = 5'(1) << INT_VBLANK;
  localparam logic [4:0]  S_ST = 5'(1) << INT_STAT;
  localparam logic [4:0]  S_TM = 5'(1) << INT_TIMER;
  localparam logic [4:0]  S_SE = 5'(1) << INT_SERIAL;
  localparam logic [4:0]  S_JP = 5'(1) << INT_JOYPAD;

  logic        clock4 = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] address = '0;
  logic [7:0]  wdata = '0;
  logic        load = 1'b0;
  logic        store = 1'b0;
  logic [7:0]  rdata;
  logic        rsel;
  logic [4:0]  src = '0;
  logic        intreq;
  logic [15:0] intaddress;
  logic        intack = 1'b0;

  always #5 clock4 = ~clock4;

  lr_intctl dut (
    .clock4     (clock4),
    .resetn     (resetn),
    .address    (address),
    .wdata      (wdata),
    .load       (load),
    .store      (store),
    .rdata      (rdata),
    .rsel       (rsel),
    .src        (src),
    .intreq     (intreq),
    .intaddress (intaddress),
    .intack     (intack)
  );

  typedef struct {
    int          cyc;
    bit          rise;
    logic [15:0] vec;
  } irq_ev_t;

  irq_ev_t    ev_q[$];
  logic [7:0] rd_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int edge_cnt    = 0;

  always @(posedge clock4) edge_cnt <= edge_cnt + 1;

  // Reference model state: IF/IE contents, last src seen, outstanding request
  int          m_if, m_ie, m_src, m_idx;
  bit          m_req;
  logic [15:0] m_vec;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Advance the model across the coming clock edge for the given inputs
  task automatic model_step(input logic [4:0] s, input logic st, input logic [15:0] a,
                            input logic [7:0] wd, input logic ld, input logic ak);
    int n_if, pend, rises;
    if (ld && a == A_IF) rd_q.push_back(8'(32'hE0 | m_if));
    else if (ld && a == A_IE) rd_q.push_back(8'(m_ie));
    rises = int'(s) & ~m_src & 'h1F;
    pend  = m_if & m_ie & 'h1F;
    if (st && a == A_IF)   n_if = int'(wd) & 'h1F;
    else if (ak && m_req)  n_if = m_if & ~(1 << m_idx);
    else                   n_if = m_if;
    n_if = n_if | rises;
    if (st && a == A_IE) m_ie = int'(wd);
    if (!m_req) begin
      if (pend != 0) begin
        m_idx = 0;
        while (((pend >> m_idx) & 1) == 0) m_idx++;
        m_vec = 16'h0040 + 16'(m_idx * 8);
        m_req = 1'b1;
        ev_q.push_back('{edge_cnt + 1, 1'b1, m_vec});
      end
    end else if (ak || ((pend >> m_idx) & 1) == 0) begin
      m_req = 1'b0;
      ev_q.push_back('{edge_cnt + 1, 1'b0, m_vec});
    end
    m_if  = n_if;
    m_src = int'(s);
  endtask

  // One bus cycle of stimulus; inputs change just after the active edge
  task automatic step(input logic [4:0] s, input logic st, input logic [15:0] a,
                      input logic [7:0] wd, input logic ld, input logic ak);
    @(posedge clock4);
    #1;
    src = s; store = st; address = a; wdata = wd; load = ld; intack = ak;
    model_step(s, st, a, wd, ld, ak);
  endtask

  task automatic idle(input int n, input logic [4:0] s);
    for (int i = 0; i < n; i++) step(s, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d, input logic [4:0] s);
    step(s, 1'b1, a, d, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [15:0] a, input logic [4:0] s);
    step(s, 1'b0, a, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic ack(input logic [4:0] s);
    step(s, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge
  task automatic do_reset();
    @(posedge clock4);
    #1;
    resetn = 1'b0;
    src = '0; store = 1'b0; load = 1'b0; intack = 1'b0; address = '0; wdata = '0;
    #1;
    chk("rst_intreq", intreq, 0);
    chk("rst_intaddress", intaddress, 0);
    address = A_IF; load = 1'b1;
    #1;
    chk("rst_if_read", rdata, 8'hE0);
    address = A_IE;
    #1;
    chk("rst_ie_read", rdata, 8'h00);
    load = 1'b0; address = '0;
    ev_q.delete();
    rd_q.delete();
    m_if = 0; m_ie = 0; m_src = 0; m_req = 1'b0; m_idx = 0; m_vec = '0;
    @(posedge clock4);
    @(posedge clock4);
    #1;
    resetn = 1'b1;
  endtask

  // Monitor: consume predicted intreq transitions and read data as they appear
  initial begin : monitor
    logic        prev;
    logic [15:0] held;
    irq_ev_t     e;
    prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clock4);
      if (!resetn) begin
        prev = 1'b0;
        continue;
      end
      while (ev_q.size() > 0 && ev_q[0].cyc < edge_cnt) begin
        e = ev_q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL irq_missing: no intreq change, want level %0d vector 0x%0h at edge %0d", e.rise, e.vec, e.cyc);
      end
      if (intreq !== prev) begin
        if (ev_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL irq_unexpected: intreq went %0b vector 0x%0h at edge %0d, want no change", intreq, intaddress, edge_cnt);
        end else begin
          e = ev_q.pop_front();
          chk("irq_edge", edge_cnt, e.cyc);
          chk("irq_level", {31'd0, intreq}, {31'd0, e.rise});
          chk("irq_vector", intaddress, e.vec);
        end
        held = intaddress;
        prev = intreq;
      end else if (intreq) begin
        chk("irq_vector_hold", intaddress, held);
      end
      if (rsel) begin
        if (rd_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rsel_unexpected: rsel high addr 0x%0h rdata 0x%0h, want rsel low", address, rdata);
        end else begin
          chk("rdata", rdata, rd_q.pop_front());
        end
      end
    end
  end

  initial begin : stimulus
    logic [4:0]  s;
    logic        st, ld, ak;
    logic [15:0] a;
    logic [7:0]  wd;
    int          r;

    do_reset();

    // Single source, enable, ack
    wr(A_IE, 8'h01, 5'h00);
    idle(3, S_VB);
    rd(A_IF, S_VB);
    ack(S_VB);
    idle(1, S_VB);
    rd(A_IF, S_VB);
    idle(1, 5'h00);

    // Two simultaneous sources, priority and follow-up request
    wr(A_IE, 8'h1F, 5'h00);
    idle(3, S_TM | S_JP);
    ack(S_TM | S_JP);
    rd(A_IF, S_TM | S_JP);
    idle(3, S_TM | S_JP);
    ack(S_TM | S_JP);
    idle(2, 5'h00);

    // Higher-priority arrival while a request is held does not re-steer
    idle(3, S_SE);
    idle(3, S_SE | S_VB);
    ack(S_SE | S_VB);
    idle(3, S_SE | S_VB);
    ack(S_SE | S_VB);
    idle(2, 5'h00);

    // IE cleared under a pending request withdraws it; re-enable restores it
    idle(3, S_ST);
    wr(A_IE, 8'h00, S_ST);
    idle(2, S_ST);
    rd(A_IF, S_ST);
    wr(A_IE, 8'h02, S_ST);
    idle(3, S_ST);
    ack(S_ST);
    idle(2, 5'h00);

    // Fresh edge beats an IF write-clear and an ack-clear in the same cycle
    wr(A_IE, 8'h1F, 5'h00);
    step(S_SE, 1'b1, A_IF, 8'h00, 1'b0, 1'b0);
    rd(A_IF, S_SE);
    idle(2, S_SE);
    idle(1, 5'h00);
    step(S_SE, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1);
    rd(A_IF, S_SE);
    idle(3, S_SE);
    ack(S_SE);
    idle(2, 5'h00);

    // Level held high sets IF once; then reset while a request is up
    idle(5, S_VB);
    ack(S_VB);
    idle(94, S_VB);
    rd(A_IF, S_VB);
    idle(1, 5'h00);
    idle(3, S_VB);
    do_reset();

    // Randomized traffic
    s = '0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) s = s ^ (5'(1) << $urandom_range(0, 4));
      st = 1'b0; ld = 1'b0; ak = 1'b0; a = 16'h0000;
      wd = 8'($urandom);
      r  = int'($urandom_range(0, 99));
      if (r < 8) begin
        st = 1'b1;
        a  = ($urandom_range(0, 1) == 0) ? A_IF : A_IE;
      end else if (r < 10) begin
        st = 1'b1;
        a  = 16'($urandom) & 16'hFEFE;
      end else if (r < 25) begin
        ld = 1'b1;
        case ($urandom_range(0, 2))
          0:       a = A_IF;
          1:       a = A_IE;
          default: a = 16'($urandom) & 16'hFEFE;
        endcase
      end
      if (m_req ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0)) ak = 1'b1;
      step(s, st, a, wd, ld, ak);
      if (n == 1500) begin
        do_reset();
        s = '0;
      end
    end

    idle(3, 5'h00);
    @(negedge clock4);
    chk("events_drained", ev_q.size(), 0);
    chk("reads_drained", rd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
